// File: rtl/uart_word_pkg.sv
// rtl/uart_word_pkg.sv - shared types and sizing helpers for uart_word_bridge
package uart_word_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        ARM   = 2'd2,
        DRAIN = 2'd3
    } tx_state_t;

    // Bits needed for a byte index covering 0..WORD_BYTES; the top value is the checksum slot.
    function automatic int byte_count_w(input int word_width);
        int slots;
        slots = word_width / 8 + 1;
        return (slots <= 2) ? 1 : $clog2(slots);
    endfunction

endpackage

// File: rtl/uart_word_rx_assembler.sv
// rtl/uart_word_rx_assembler.sv - byte-to-word assembler with inter-byte timeout; optional UART_WORD_CHECKSUM_EN
module uart_word_rx_assembler
    import uart_word_pkg::*;
#(
    parameter int WORD_WIDTH        = 64,
    parameter int RX_TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  word_valid,
    output logic [WORD_WIDTH-1:0] word_data,
    output logic                  rx_error
);

    localparam int WORD_BYTES = WORD_WIDTH / 8;
    localparam int CW         = byte_count_w(WORD_WIDTH);
`ifdef UART_WORD_CHECKSUM_EN
    localparam int FRAME_BYTES = WORD_BYTES + 1;
`else
    localparam int FRAME_BYTES = WORD_BYTES;
`endif
    localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_BYTES - 1);
    // The idle counter only ever needs to reach RX_TIMEOUT_CYCLES-1.
    localparam int TW = (RX_TIMEOUT_CYCLES < 2) ? 1 : $clog2(RX_TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_LAST = TW'((RX_TIMEOUT_CYCLES > 0) ? RX_TIMEOUT_CYCLES - 1 : 0);

    logic [CW-1:0]         count;
    logic [TW-1:0]         idle_cnt;
    logic [WORD_WIDTH-1:0] shadow;
    logic [WORD_WIDTH-1:0] shadow_next;
    logic                  last_byte;
    logic                  timeout_hit;
    logic                  csum_ok;

    // Shadow word with the incoming byte merged in, so the final byte lands in word_data directly.
    always_comb begin
        shadow_next = shadow;
        if (int'(count) < WORD_BYTES) begin
            shadow_next[{count, 3'b000} +: 8] = byte_data;
        end
    end

    assign last_byte   = (count == LAST_SLOT);
    assign timeout_hit = (RX_TIMEOUT_CYCLES != 0) && (count != '0) && (idle_cnt == T_LAST);

`ifdef UART_WORD_CHECKSUM_EN
    logic [7:0] csum;

    assign csum_ok = (byte_data == csum);

    // Running XOR of the data bytes; restarts with the first byte of every frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= 8'h00;
        end else if (byte_valid) begin
            csum <= (count == '0) ? byte_data : (csum ^ byte_data);
        end
    end
`else
    assign csum_ok = 1'b1;
`endif

    // Byte capture, word completion and timeout discard; a byte always beats an expiring timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            idle_cnt   <= '0;
            shadow     <= '0;
            word_data  <= '0;
            word_valid <= 1'b0;
            rx_error   <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            rx_error   <= 1'b0;
            if (byte_valid) begin
                idle_cnt <= '0;
                shadow   <= shadow_next;
                if (last_byte) begin
                    count <= '0;
                    if (csum_ok) begin
                        word_data  <= shadow_next;
                        word_valid <= 1'b1;
                    end else begin
                        rx_error <= 1'b1;
                    end
                end else begin
                    count <= count + 1'b1;
                end
            end else if (timeout_hit) begin
                count    <= '0;
                idle_cnt <= '0;
                rx_error <= 1'b1;
            end else if (count != '0) begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_word_bridge.sv
// rtl/uart_word_bridge.sv - UART byte/word bridge top with TX serialiser FSM; optional UART_WORD_CHECKSUM_EN
module uart_word_bridge
    import uart_word_pkg::*;
#(
    parameter int WORD_WIDTH        = 64,
    parameter int RX_TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  rx_byte_valid_in,
    input  logic [7:0]            rx_byte_in,
    output logic                  word_valid_out,
    output logic [WORD_WIDTH-1:0] word_out,
    output logic                  rx_error_out,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid_in,
    output logic                  word_ready_out,
    output logic [7:0]            tx_byte_out,
    output logic                  tx_trigger_out,
    input  logic                  tx_busy_in
);

    localparam int WORD_BYTES = WORD_WIDTH / 8;
    localparam int CW         = byte_count_w(WORD_WIDTH);
`ifdef UART_WORD_CHECKSUM_EN
    localparam int TX_FRAME = WORD_BYTES + 1;
`else
    localparam int TX_FRAME = WORD_BYTES;
`endif
    localparam logic [CW-1:0] TX_LAST = CW'(TX_FRAME - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [WORD_WIDTH-1:0] tx_word;
    logic [CW-1:0]         tx_idx;
    logic [7:0]            tx_sel;

    uart_word_rx_assembler #(
        .WORD_WIDTH        (WORD_WIDTH),
        .RX_TIMEOUT_CYCLES (RX_TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk_in),
        .rst_n      (rst_n_in),
        .byte_valid (rx_byte_valid_in),
        .byte_data  (rx_byte_in),
        .word_valid (word_valid_out),
        .word_data  (word_out),
        .rx_error   (rx_error_out)
    );

    // Byte selected by the TX index; the slot past the data bytes carries the XOR checksum.
    always_comb begin
        tx_sel = 8'h00;
        for (int k = 0; k < WORD_BYTES; k++) begin
            if (int'(tx_idx) == k) tx_sel = tx_word[8*k +: 8];
        end
`ifdef UART_WORD_CHECKSUM_EN
        if (int'(tx_idx) == WORD_BYTES) begin
            tx_sel = 8'h00;
            for (int k = 0; k < WORD_BYTES; k++) tx_sel = tx_sel ^ tx_word[8*k +: 8];
        end
`endif
    end

    // The byte stays stable from SEND until DRAIN exits because the index only moves on DRAIN exit.
    assign tx_byte_out = tx_sel;

    // TX state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else           state <= state_next;
    end

    // TX next-state and handshake outputs, paced by the transmitter busy flag.
    always_comb begin
        state_next     = state;
        word_ready_out = 1'b0;
        tx_trigger_out = 1'b0;
        case (state)
            IDLE: begin
                word_ready_out = 1'b1;
                if (word_valid_in) state_next = SEND;
            end
            SEND: begin
                tx_trigger_out = 1'b1;
                state_next     = ARM;
            end
            ARM: begin
                if (tx_busy_in) state_next = DRAIN;
            end
            DRAIN: begin
                if (!tx_busy_in) state_next = (tx_idx == TX_LAST) ? IDLE : SEND;
            end
            default: state_next = IDLE;
        endcase
    end

    // Word latch on acceptance and byte index advance after each drained byte.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_word <= '0;
            tx_idx  <= '0;
        end else if (state == IDLE && word_valid_in) begin
            tx_word <= word_in;
            tx_idx  <= '0;
        end else if (state == DRAIN && !tx_busy_in && tx_idx != TX_LAST) begin
            tx_idx <= tx_idx + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_word_bridge.sv
// tb/tb_uart_word_bridge.sv - self-checking bench for uart_word_bridge; optional UART_WORD_CHECKSUM_EN
module tb_uart_word_bridge;

    localparam int WB = 4;
    localparam int T  = 100;
`ifdef UART_WORD_CHECKSUM_EN
    localparam int FB = WB + 1;
`else
    localparam int FB = WB;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx_v;
    logic [7:0]  rx_b;
    logic        wv_o;
    logic [31:0] w_o;
    logic        err_o;
    logic [31:0] w_in;
    logic        wv_in;
    logic        rdy;
    logic [7:0]  txb;
    logic        trig;
    logic        busy;

    int total = 0;
    int bad   = 0;

    longint      cyc = 0;
    int          m_cnt = 0;
    logic [7:0]  m_bytes [WB];
    logic [7:0]  m_x;
    longint      m_last = 0;
    logic [31:0] m_word = 0;
    logic        m_valid = 0;
    logic        m_err = 0;
    logic        m_ok;
    logic [7:0]  txq [$];
    logic [7:0]  trig_log [$];
    int          valid_seen = 0;
    int          err_seen = 0;
    int          busy_left = 0;

    uart_word_bridge #(
        .WORD_WIDTH        (32),
        .RX_TIMEOUT_CYCLES (T)
    ) dut (
        .clk_in           (clk),
        .rst_n_in         (rst_n),
        .rx_byte_valid_in (rx_v),
        .rx_byte_in       (rx_b),
        .word_valid_out   (wv_o),
        .word_out         (w_o),
        .rx_error_out     (err_o),
        .word_in          (w_in),
        .word_valid_in    (wv_in),
        .word_ready_out   (rdy),
        .tx_byte_out      (txb),
        .tx_trigger_out   (trig),
        .tx_busy_in       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Fake uart_transmit: busy for 20 cycles after each trigger.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_left = 0;
            busy = 1'b0;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) busy = 1'b0;
        end else if (trig) begin
            busy = 1'b1;
            busy_left = 20;
        end
    end

    // Model and per-cycle comparison: outputs now reflect inputs of the previous cycle.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_cnt = 0; m_word = 0; m_valid = 0; m_err = 0;
            txq.delete();
        end
        chk("word_valid", {31'b0, wv_o}, {31'b0, m_valid});
        chk("word_out", w_o, m_word);
        chk("rx_error", {31'b0, err_o}, {31'b0, m_err});
        if (wv_o) valid_seen++;
        if (err_o) err_seen++;
        if (trig) begin
            chk("tx_pending", {31'b0, txq.size() != 0}, 32'd1);
            if (txq.size() != 0) chk("tx_byte", {24'b0, txb}, {24'b0, txq.pop_front()});
            trig_log.push_back(txb);
        end
        m_valid = 0;
        m_err = 0;
        if (rst_n) begin
            if (rx_v) begin
                if (m_cnt < WB) m_bytes[m_cnt] = rx_b;
                m_cnt++;
                m_last = cyc;
                if (m_cnt == FB) begin
                    m_cnt = 0;
                    m_x = 8'h00;
                    for (int i = 0; i < WB; i++) m_x ^= m_bytes[i];
                    m_ok = (FB == WB) || (rx_b == m_x);
                    if (m_ok) begin
                        m_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                        m_valid = 1;
                    end else begin
                        m_err = 1;
                    end
                end
            end else if (m_cnt > 0 && cyc - m_last == T) begin
                m_cnt = 0;
                m_err = 1;
            end
            if (wv_in && rdy) begin
                m_x = 8'h00;
                for (int i = 0; i < WB; i++) begin
                    txq.push_back(w_in[8*i +: 8]);
                    m_x ^= w_in[8*i +: 8];
                end
                if (FB > WB) txq.push_back(m_x);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rx_byte(input logic [7:0] b, input int gap);
        idle(gap);
        rx_v = 1'b1;
        rx_b = b;
        idle(1);
        rx_v = 1'b0;
    endtask

    task automatic rx_word(input logic [31:0] w, input int gap_at, input int gap);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < WB; i++) begin
            rx_byte(w[8*i +: 8], (i == gap_at) ? gap : 0);
            x ^= w[8*i +: 8];
        end
        if (FB > WB) rx_byte(x, 0);
        idle(2);
    endtask

    task automatic tx_word(input logic [31:0] w);
        int n;
        n = 0;
        while (!rdy && n < 1000) begin idle(1); n++; end
        trig_log.delete();
        w_in = w;
        wv_in = 1'b1;
        idle(1);
        wv_in = 1'b0;
        w_in = ~w;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!rdy && n < budget) begin idle(1); n++; end
        idle(1);
        chk("tx_ready_back", {31'b0, rdy}, 32'd1);
        chk("tx_drained", txq.size(), 32'd0);
        chk("tx_count", trig_log.size(), FB);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rx_v = 1'b0; rx_b = 8'h00; w_in = '0; wv_in = 1'b0;
        idle(2);
        chk("rst_ready", {31'b0, rdy}, 32'd1);
        chk("rst_trigger", {31'b0, trig}, 32'd0);
        chk("rst_tx_byte", {24'b0, txb}, 32'd0);
        chk("rst_word", w_o, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Plain word.
        valid_seen = 0; err_seen = 0;
        rx_word(32'h44332211, 0, 0);
        chk("s1_word", w_o, 32'h44332211);
        chk("s1_valid_count", valid_seen, 32'd1);

        // Partial word dropped after 100 idle cycles, then a full word.
        valid_seen = 0; err_seen = 0;
        rx_byte(8'h55, 0);
        rx_byte(8'h66, 0);
        rx_word(32'hDDCCBBAA, 0, 100);
        chk("s2_err_count", err_seen, 32'd1);
        chk("s2_word", w_o, 32'hDDCCBBAA);
        chk("s2_valid_count", valid_seen, 32'd1);

        // Byte lands exactly on the expiry cycle: accepted, no error.
        valid_seen = 0; err_seen = 0;
        rx_word(32'h04030201, 2, T - 1);
        chk("s3_err_count", err_seen, 32'd0);
        chk("s3_word", w_o, 32'h04030201);

`ifdef UART_WORD_CHECKSUM_EN
        // Bad checksum leaves word_out alone.
        valid_seen = 0; err_seen = 0;
        rx_byte(8'h01, 0); rx_byte(8'h02, 0); rx_byte(8'h03, 0); rx_byte(8'h04, 0);
        rx_byte(8'h05, 0);
        idle(2);
        chk("ck_err_count", err_seen, 32'd1);
        chk("ck_valid_count", valid_seen, 32'd0);
        chk("ck_word_kept", w_o, 32'h04030201);
`endif

        // Transmit with busy pacing.
        tx_word(32'hCAFEF00D);
        wait_ready(500);
        chk("t1_b0", {24'b0, trig_log[0]}, 32'h0D);
        chk("t1_b1", {24'b0, trig_log[1]}, 32'hF0);
        chk("t1_b2", {24'b0, trig_log[2]}, 32'hFE);
        chk("t1_b3", {24'b0, trig_log[3]}, 32'hCA);

        // Back-to-back word.
        tx_word(32'h04030201);
        wait_ready(500);
        chk("t2_b0", {24'b0, trig_log[0]}, 32'h01);
        chk("t2_b3", {24'b0, trig_log[3]}, 32'h04);
`ifdef UART_WORD_CHECKSUM_EN
        chk("t2_csum", {24'b0, trig_log[4]}, 32'h04);
`endif

        // Reset mid-transmission and mid-receive.
        tx_word(32'hA1B2C3D4);
        rx_byte(8'h77, 0);
        rx_byte(8'h88, 0);
        begin
            int n;
            n = 0;
            while (trig_log.size() < 2 && n < 300) begin idle(1); n++; end
            chk("rst_reach_byte2", trig_log.size(), 32'd2);
        end
        idle(3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", {31'b0, rdy}, 32'd1);
        chk("arst_trigger", {31'b0, trig}, 32'd0);
        chk("arst_tx_byte", {24'b0, txb}, 32'd0);
        chk("arst_word", w_o, 32'd0);
        chk("arst_valid", {31'b0, wv_o}, 32'd0);
        chk("arst_err", {31'b0, err_o}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        valid_seen = 0; err_seen = 0;
        rx_word(32'h89ABCDEF, 0, 0);
        chk("post_word", w_o, 32'h89ABCDEF);
        chk("post_err_count", err_seen, 32'd0);
        tx_word(32'h5A5AC33C);
        wait_ready(500);
        chk("post_b0", {24'b0, trig_log[0]}, 32'h3C);
        chk("post_b3", {24'b0, trig_log[3]}, 32'h5A);

        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
